// File: rtl/dat_pkg.sv
// Shared types for the DAT transfer sequencer.
// One-hot state encoding, default widths and error causes.
package dat_pkg;

  localparam int DEF_BLK_CNT_W = 16;
  localparam int DEF_TIMEOUT_W = 24;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_WR_START = 8'b0000_0010,
    S_WR_XFER  = 8'b0000_0100,
    S_RD_START = 8'b0000_1000,
    S_RD_XFER  = 8'b0001_0000,
    S_BLK_GAP  = 8'b0010_0000,
    S_DONE     = 8'b0100_0000,
    S_ERR      = 8'b1000_0000
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_CRC     = 2'd2
  } err_cause_t;

endpackage

// File: rtl/dat_timeout_cnt.sv
// Loadable data-timeout down-counter.
// expire flags the cycle whose decrement lands on zero.
module dat_timeout_cnt
  import dat_pkg::*;
#(
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  input  logic                 en,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // cnt of 0 or 1 while counting: time is up
  assign expire = en & (cnt[TIMEOUT_W-1:1] == '0);

endmodule

// File: rtl/dat_xfer_control.sv
// DAT-line transfer sequencer: single, counted and
// infinite multi-block modes with timeout, CRC and abort.
module dat_xfer_control
  import dat_pkg::*;
#(
  parameter int BLK_CNT_W = DEF_BLK_CNT_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                 host_clk,
  input  logic                 rst,
  input  logic                 tx_data_init,
  input  logic                 rx_data_init,
  input  logic                 multi_blk_en,
  input  logic                 blk_cnt_en,
  input  logic [BLK_CNT_W-1:0] blk_count,
  input  logic                 auto_cmd12_en,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 abort,
  input  logic                 tx_buf_empty,
  input  logic                 rx_buf_full,
  input  logic                 dat_phys_busy,
  input  logic                 blk_done,
  input  logic                 crc_err,
  output logic                 dat_wr_flag,
  output logic                 dat_rd_flag,
  output logic                 wr_xfer_active,
  output logic                 rd_xfer_active,
  output logic [BLK_CNT_W-1:0] blks_remaining,
  output logic                 xfer_complete,
  output logic                 timeout_err,
  output logic                 crc_err_flag,
  output logic                 stop_req
);

  state_t     state, nxt;
  err_cause_t cause;

  logic dir_wr, inf_mode, stop_en;
  logic ld_start, set_wr, set_rd, clr_act, dec;
  logic p_cmpl, p_stop;
  logic tmr_ld, tmr_en, expire;
  logic zero_cnt;

  assign zero_cnt = multi_blk_en & blk_cnt_en &
                    (blk_count == '0);

  assign tmr_ld = ld_start | blk_done;
  assign tmr_en = (timeout_val != '0) &
                  (state inside {S_WR_START, S_WR_XFER,
                                 S_RD_START, S_RD_XFER,
                                 S_BLK_GAP});

  dat_timeout_cnt #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_tmr (
    .clk     (host_clk),
    .rst     (rst),
    .load    (tmr_ld),
    .load_val(timeout_val),
    .en      (tmr_en),
    .expire  (expire)
  );

  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    cause       = CAUSE_NONE;
    ld_start    = 1'b0;
    set_wr      = 1'b0;
    set_rd      = 1'b0;
    dec         = 1'b0;
    p_stop      = 1'b0;
    dat_wr_flag = 1'b0;
    dat_rd_flag = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tx_data_init ^ rx_data_init) begin
          ld_start = 1'b1;
          if (zero_cnt) begin
            nxt = S_DONE;
          end else if (tx_data_init) begin
            nxt    = S_WR_START;
            set_wr = 1'b1;
          end else begin
            nxt    = S_RD_START;
            set_rd = 1'b1;
          end
        end
      end
      S_WR_START, S_RD_START: begin
        if (abort) begin
          nxt = S_DONE;
        end else if (expire) begin
          nxt   = S_ERR;
          cause = CAUSE_TIMEOUT;
        end else if (state == S_WR_START) begin
          dat_wr_flag = ~tx_buf_empty & ~dat_phys_busy;
          if (dat_wr_flag) nxt = S_WR_XFER;
        end else begin
          dat_rd_flag = ~rx_buf_full & ~dat_phys_busy;
          if (dat_rd_flag) nxt = S_RD_XFER;
        end
      end
      S_WR_XFER, S_RD_XFER: begin
        if (abort) begin
          nxt = S_DONE;
        end else if (blk_done) begin
          dat_wr_flag = (state == S_WR_XFER) & ~tx_buf_empty;
          dat_rd_flag = (state == S_RD_XFER) & ~rx_buf_full;
          if (crc_err) begin
            nxt   = S_ERR;
            cause = CAUSE_CRC;
          end else if (inf_mode) begin
            nxt = S_BLK_GAP;
          end else begin
            dec = 1'b1;
            if (blks_remaining[BLK_CNT_W-1:1] == '0) begin
              nxt    = S_DONE;
              p_stop = stop_en;
            end else begin
              nxt = S_BLK_GAP;
            end
          end
        end else if (expire) begin
          nxt   = S_ERR;
          cause = CAUSE_TIMEOUT;
        end else begin
          dat_wr_flag = (state == S_WR_XFER) & ~tx_buf_empty;
          dat_rd_flag = (state == S_RD_XFER) & ~rx_buf_full;
        end
      end
      S_BLK_GAP: begin
        if (abort) begin
          nxt = S_DONE;
        end else if (expire) begin
          nxt   = S_ERR;
          cause = CAUSE_TIMEOUT;
        end else if (!dat_phys_busy) begin
          nxt = dir_wr ? S_WR_START : S_RD_START;
        end
      end
      S_DONE, S_ERR: nxt = S_IDLE;
      default:       nxt = S_IDLE;
    endcase
  end

  // DONE and ERR are only ever entered from elsewhere
  assign p_cmpl  = (nxt == S_DONE) & (state != S_DONE);
  assign clr_act = p_cmpl | (cause != CAUSE_NONE);

  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) begin
      dir_wr         <= 1'b0;
      inf_mode       <= 1'b0;
      stop_en        <= 1'b0;
      blks_remaining <= '0;
      wr_xfer_active <= 1'b0;
      rd_xfer_active <= 1'b0;
      xfer_complete  <= 1'b0;
      timeout_err    <= 1'b0;
      crc_err_flag   <= 1'b0;
      stop_req       <= 1'b0;
    end else begin
      xfer_complete <= p_cmpl;
      timeout_err   <= (cause == CAUSE_TIMEOUT);
      crc_err_flag  <= (cause == CAUSE_CRC);
      stop_req      <= p_stop;
      if (ld_start) begin
        dir_wr   <= tx_data_init;
        inf_mode <= multi_blk_en & ~blk_cnt_en;
        stop_en  <= multi_blk_en & blk_cnt_en &
                    auto_cmd12_en & (blk_count != '0);
        blks_remaining <= multi_blk_en ? blk_count :
                          {{(BLK_CNT_W-1){1'b0}}, 1'b1};
      end else if (dec && blks_remaining != '0) begin
        blks_remaining <= blks_remaining - 1'b1;
      end
      if (set_wr)       wr_xfer_active <= 1'b1;
      else if (clr_act) wr_xfer_active <= 1'b0;
      if (set_rd)       rd_xfer_active <= 1'b1;
      else if (clr_act) rd_xfer_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dat_xfer_control.sv
// Scoreboard bench for dat_xfer_control: directed stimulus
// queues expected pulse events, a monitor pops and compares.
module tb_dat_xfer_control;

  logic        host_clk = 1'b0;
  logic        rst;
  logic        tx_data_init, rx_data_init;
  logic        multi_blk_en, blk_cnt_en, auto_cmd12_en;
  logic [15:0] blk_count;
  logic [23:0] timeout_val;
  logic        abort, tx_buf_empty, rx_buf_full;
  logic        dat_phys_busy, blk_done, crc_err;
  logic        dat_wr_flag, dat_rd_flag;
  logic        wr_xfer_active, rd_xfer_active;
  logic [15:0] blks_remaining;
  logic        xfer_complete, timeout_err;
  logic        crc_err_flag, stop_req;

  typedef struct packed {
    logic        cmpl;
    logic        tmo;
    logic        crc;
    logic        stop;
    logic [15:0] blks;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  dat_xfer_control dut (
    .host_clk      (host_clk),
    .rst           (rst),
    .tx_data_init  (tx_data_init),
    .rx_data_init  (rx_data_init),
    .multi_blk_en  (multi_blk_en),
    .blk_cnt_en    (blk_cnt_en),
    .blk_count     (blk_count),
    .auto_cmd12_en (auto_cmd12_en),
    .timeout_val   (timeout_val),
    .abort         (abort),
    .tx_buf_empty  (tx_buf_empty),
    .rx_buf_full   (rx_buf_full),
    .dat_phys_busy (dat_phys_busy),
    .blk_done      (blk_done),
    .crc_err       (crc_err),
    .dat_wr_flag   (dat_wr_flag),
    .dat_rd_flag   (dat_rd_flag),
    .wr_xfer_active(wr_xfer_active),
    .rd_xfer_active(rd_xfer_active),
    .blks_remaining(blks_remaining),
    .xfer_complete (xfer_complete),
    .timeout_err   (timeout_err),
    .crc_err_flag  (crc_err_flag),
    .stop_req      (stop_req)
  );

  always #5 host_clk = ~host_clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic push(input logic c, input logic t,
                      input logic r, input logic s,
                      input logic [15:0] b);
    exp_q.push_back('{c, t, r, s, b});
  endtask

  task automatic tick();
    @(posedge host_clk);
    #1;
  endtask

  always @(negedge host_clk) begin
    if (!rst && (xfer_complete | timeout_err |
                 crc_err_flag | stop_req)) begin
      ev_t got, exp;
      got = '{xfer_complete, timeout_err, crc_err_flag,
              stop_req, blks_remaining};
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(got), 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("event", 32'(got), 32'(exp));
        check("active_clr_on_event",
              {30'd0, wr_xfer_active, rd_xfer_active}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tx_data_init = 0; rx_data_init = 0;
    multi_blk_en = 0; blk_cnt_en = 0; auto_cmd12_en = 0;
    blk_count = 0; timeout_val = 0; abort = 0;
    tx_buf_empty = 0; rx_buf_full = 0; dat_phys_busy = 0;
    blk_done = 0; crc_err = 0;
    #3;
    check("reset_outputs",
          {dat_wr_flag, dat_rd_flag, wr_xfer_active,
           rd_xfer_active, blks_remaining, xfer_complete,
           timeout_err, crc_err_flag, stop_req}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: single write
    tx_data_init = 1;
    check("t1_idle_no_flag", dat_wr_flag, 0);
    tick();
    tx_data_init = 0;
    check("t1_wr_flag_start", dat_wr_flag, 1);
    check("t1_wr_active", wr_xfer_active, 1);
    check("t1_blks_1", blks_remaining, 1);
    tick();
    check("t1_wr_flag_xfer", dat_wr_flag, 1);
    push(1, 0, 0, 0, 16'd0);
    blk_done = 1;
    tick();
    blk_done = 0;
    check("t1_cmpl", xfer_complete, 1);
    check("t1_wr_active_clr", wr_xfer_active, 0);
    tick();
    check("t1_cmpl_one_cycle", xfer_complete, 0);

    // 2: counted multi-read of 3 with auto CMD12
    multi_blk_en = 1; blk_cnt_en = 1; auto_cmd12_en = 1;
    blk_count = 3;
    rx_data_init = 1;
    tick();
    rx_data_init = 0;
    check("t2_rd_active", rd_xfer_active, 1);
    check("t2_blks_3", blks_remaining, 3);
    check("t2_rd_flag", dat_rd_flag, 1);
    tick();
    for (int b = 0; b < 3; b++) begin
      if (b == 2) push(1, 0, 0, 1, 16'd0);
      else dat_phys_busy = 1;
      blk_done = 1;
      tick();
      blk_done = 0;
      if (b < 2) begin
        check("t2_blks_dec", blks_remaining, 32'(2 - b));
        check("t2_gap_no_flag", dat_rd_flag, 0);
        tick(); tick();
        check("t2_gap_hold", dat_rd_flag, 0);
        check("t2_stays_active", rd_xfer_active, 1);
        dat_phys_busy = 0;
        tick();
        check("t2_restart_flag", dat_rd_flag, 1);
        tick();
      end
    end
    check("t2_cmpl_stop", {xfer_complete, stop_req}, 2'b11);
    tick();
    auto_cmd12_en = 0;

    // 3: read timeout after 10 counting cycles
    multi_blk_en = 0; blk_cnt_en = 0;
    timeout_val = 24'd10; rx_buf_full = 1;
    push(0, 1, 0, 0, 16'd1);
    rx_data_init = 1;
    tick();
    rx_data_init = 0;
    begin
      int n = 0;
      while (!timeout_err && n < 40) begin
        tick();
        n++;
      end
      check("t3_tmo_cycles", n, 10);
    end
    check("t3_no_cmpl", xfer_complete, 0);
    check("t3_rd_active_clr", rd_xfer_active, 0);
    tick();
    timeout_val = 0; rx_buf_full = 0;

    // 4: CRC error on second block of a 4-block write
    multi_blk_en = 1; blk_cnt_en = 1; blk_count = 4;
    tx_data_init = 1;
    tick();
    tx_data_init = 0;
    tick();
    crc_err = 1;
    tick();
    crc_err = 0;
    check("t4_crc_alone_ignored", blks_remaining, 4);
    blk_done = 1;
    tick();
    blk_done = 0;
    check("t4_blks_3", blks_remaining, 3);
    tick(); tick();
    push(0, 0, 1, 0, 16'd3);
    blk_done = 1; crc_err = 1;
    tick();
    blk_done = 0; crc_err = 0;
    check("t4_crc_flag", crc_err_flag, 1);
    check("t4_blks_held", blks_remaining, 3);
    tick();
    check("t4_idle_no_flag", dat_wr_flag, 0);

    // 5: infinite write ended by abort
    blk_cnt_en = 0; blk_count = 2;
    tx_data_init = 1;
    tick();
    tx_data_init = 0;
    tick();
    for (int b = 0; b < 5; b++) begin
      blk_done = 1;
      tick();
      blk_done = 0;
      check("t5_inf_blks_hold", blks_remaining, 2);
      tick(); tick();
    end
    check("t5_still_active", wr_xfer_active, 1);
    abort = 1;
    #1;
    check("t5_abort_flag_off", dat_wr_flag, 0);
    push(1, 0, 0, 0, 16'd2);
    tick();
    abort = 0;
    check("t5_abort_cmpl", {xfer_complete, stop_req}, 2'b10);
    tick();

    // 5b: abort coincident with blk_done on counted run
    blk_cnt_en = 1; auto_cmd12_en = 1;
    tx_data_init = 1;
    tick();
    tx_data_init = 0;
    tick();
    push(1, 0, 0, 0, 16'd2);
    abort = 1; blk_done = 1;
    tick();
    abort = 0; blk_done = 0;
    check("t5b_abort_wins_blks", blks_remaining, 2);
    tick();

    // 6a: both inits high stays idle
    tx_data_init = 1; rx_data_init = 1;
    tick(); tick();
    check("t6a_both_idle",
          {dat_wr_flag, dat_rd_flag,
           wr_xfer_active, rd_xfer_active}, 0);
    tx_data_init = 0; rx_data_init = 0;
    tick();

    // 6b: zero block count gives immediate completion
    blk_count = 0;
    push(1, 0, 0, 0, 16'd0);
    tx_data_init = 1;
    tick();
    tx_data_init = 0;
    check("t6b_zero_no_active", wr_xfer_active, 0);
    check("t6b_zero_no_flag", dat_wr_flag, 0);
    check("t6b_zero_cmpl", xfer_complete, 1);
    tick();
    auto_cmd12_en = 0; multi_blk_en = 0; blk_cnt_en = 0;

    // 6c: blk_done beats simultaneous timer expiry
    timeout_val = 24'd3;
    tx_data_init = 1;
    tick();
    tx_data_init = 0;
    tick(); tick();
    push(1, 0, 0, 0, 16'd0);
    blk_done = 1;
    tick();
    blk_done = 0;
    check("t6c_done_wins", {xfer_complete, timeout_err}, 2'b10);
    tick();
    timeout_val = 0;

    // 6d: async reset mid WR_XFER
    tx_data_init = 1;
    tick();
    tx_data_init = 0;
    tick();
    check("t6d_in_xfer", wr_xfer_active, 1);
    #2 rst = 1;
    #1;
    check("t6d_async_rst",
          {dat_wr_flag, wr_xfer_active, blks_remaining}, 0);
    tick();
    rst = 0;
    tick();
    check("t6d_idle_after", dat_wr_flag, 0);

    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
